argmax_signed_16: RTL and testbench

//  Finds the maximum of 16 signed WIDTH-bit values and the index of that maximum.

---
 rtl/argmax_signed_16.sv | 169 ++++++++++++++++
 tb/tb_argmax_signed_16.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/argmax_signed_16.sv
// argmax_signed_16: pipelined signed maximum / argmax over 16 elements.
// Four registered comparator levels (16 -> 8 -> 4 -> 2 -> 1) give a fixed
// 4-cycle latency at one vector per clock. Each node keeps the higher-index
// candidate on ties, so equal maxima resolve to the highest element index.
module argmax_signed_16 #(
    parameter int WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [16*WIDTH-1:0]     in_flat,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] max,
    output logic [3:0]              argmax
);

    // Unpacked view of the input vector
    logic signed [WIDTH-1:0] elem [16];

    // Level 1: 8 winners, 1-bit local index
    logic signed [WIDTH-1:0] l1_val_d [8];
    logic [0:0]              l1_idx_d [8];
    logic signed [WIDTH-1:0] l1_val   [8];
    logic [0:0]              l1_idx   [8];

    // Level 2: 4 winners, 2-bit local index
    logic signed [WIDTH-1:0] l2_val_d [4];
    logic [1:0]              l2_idx_d [4];
    logic signed [WIDTH-1:0] l2_val   [4];
    logic [1:0]              l2_idx   [4];

    // Level 3: 2 winners, 3-bit local index
    logic signed [WIDTH-1:0] l3_val_d [2];
    logic [2:0]              l3_idx_d [2];
    logic signed [WIDTH-1:0] l3_val   [2];
    logic [2:0]              l3_idx   [2];

    // Level 4: final winner, full 4-bit index
    logic signed [WIDTH-1:0] l4_val_d;
    logic [3:0]              l4_idx_d;
    logic signed [WIDTH-1:0] l4_val;
    logic [3:0]              l4_idx;

    // Valid travels beside the data, one stage per level
    logic [3:0]              vld_pipe;

    // Split the flat bus into signed elements
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            elem[i] = in_flat[i*WIDTH +: WIDTH];
        end
    end

    // Level 1 compare: B (odd element) wins when B >= A
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            l1_val_d[k] = elem[2*k];
            l1_idx_d[k] = 1'b0;
            if (elem[2*k+1] >= elem[2*k]) begin
                l1_val_d[k] = elem[2*k+1];
                l1_idx_d[k] = 1'b1;
            end
        end
    end

    // Level 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 8; k++) begin
                l1_val[k] <= '0;
                l1_idx[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 8; k++) begin
                l1_val[k] <= l1_val_d[k];
                l1_idx[k] <= l1_idx_d[k];
            end
        end
    end

    // Level 2 compare: winner side becomes the new index MSB
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            l2_val_d[k] = l1_val[2*k];
            l2_idx_d[k] = {1'b0, l1_idx[2*k]};
            if (l1_val[2*k+1] >= l1_val[2*k]) begin
                l2_val_d[k] = l1_val[2*k+1];
                l2_idx_d[k] = {1'b1, l1_idx[2*k+1]};
            end
        end
    end

    // Level 2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 4; k++) begin
                l2_val[k] <= '0;
                l2_idx[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                l2_val[k] <= l2_val_d[k];
                l2_idx[k] <= l2_idx_d[k];
            end
        end
    end

    // Level 3 compare
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            l3_val_d[k] = l2_val[2*k];
            l3_idx_d[k] = {1'b0, l2_idx[2*k]};
            if (l2_val[2*k+1] >= l2_val[2*k]) begin
                l3_val_d[k] = l2_val[2*k+1];
                l3_idx_d[k] = {1'b1, l2_idx[2*k+1]};
            end
        end
    end

    // Level 3 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 2; k++) begin
                l3_val[k] <= '0;
                l3_idx[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                l3_val[k] <= l3_val_d[k];
                l3_idx[k] <= l3_idx_d[k];
            end
        end
    end

    // Level 4 compare: upper half (elements 8..15) wins ties
    always_comb begin
        l4_val_d = l3_val[0];
        l4_idx_d = {1'b0, l3_idx[0]};
        if (l3_val[1] >= l3_val[0]) begin
            l4_val_d = l3_val[1];
            l4_idx_d = {1'b1, l3_idx[1]};
        end
    end

    // Level 4 registers drive the outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l4_val <= '0;
            l4_idx <= '0;
        end else begin
            l4_val <= l4_val_d;
            l4_idx <= l4_idx_d;
        end
    end

    // Valid shift chain matching the four data stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:0], in_valid};
        end
    end

    assign out_valid = vld_pipe[3];
    assign max       = l4_val;
    assign argmax    = l4_idx;

endmodule

// File: tb/tb_argmax_signed_16.sv
// Directed bench for argmax_signed_16 with hand-computed expectations.
module tb_argmax_signed_16;

    localparam int WIDTH = 5;

    typedef int vec_t [16];

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic [16*WIDTH-1:0]     in_flat;
    logic                    out_valid;
    logic signed [WIDTH-1:0] max_o;
    logic [3:0]              argmax_o;

    int checks = 0;
    int errors = 0;

    argmax_signed_16 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_flat   (in_flat),
        .out_valid (out_valid),
        .max       (max_o),
        .argmax    (argmax_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t v_desc;
    vec_t v_zero  = '{16{0}};
    vec_t v_mixed = '{-12, 2, 11, 9, 8, -14, -8, -13, -1, 8, -2, -1, 4, -4, 9, -10};
    vec_t v_full  = '{-2, 9, 6, 6, 13, 1, -16, 8, -8, -3, 11, -13, 14, 7, -4, 10};
    vec_t v_strm  = '{-15, 12, -16, 1, -1, 1, -9, -5, 6, 2, -12, -6, -6, 0, -6, 1};
    vec_t v_neg   = '{16{-16}};
    vec_t v_last  = '{-16, -16, -16, -16, -16, -16, -16, -16,
                      -16, -16, -16, -16, -16, -16, -16, 15};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16*WIDTH-1:0] pack(input vec_t v);
        logic [16*WIDTH-1:0] r;
        int tmp;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            tmp = v[i];
            r[i*WIDTH +: WIDTH] = tmp[WIDTH-1:0];
        end
        return r;
    endfunction

    task automatic check_out(input string tag, input int vld, input int mx, input int idx);
        check({tag, ".valid"}, int'(out_valid), vld);
        if (vld != 0) begin
            check({tag, ".max"}, int'(max_o), mx);
            check({tag, ".argmax"}, int'(argmax_o), idx);
        end
    endtask

    // One isolated vector; also confirms the result is not early
    task automatic run_single(input string tag, input vec_t v, input int mx, input int idx);
        @(negedge clk);
        in_flat  = pack(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_flat  = '0;
        repeat (2) @(negedge clk);
        check({tag, ".early"}, int'(out_valid), 0);
        @(negedge clk);
        check_out(tag, 1, mx, idx);
        @(negedge clk);
        check({tag, ".after"}, int'(out_valid), 0);
    endtask

    initial begin
        int exp_mx  [4];
        int exp_idx [4];
        vec_t svec  [4];

        for (int i = 0; i < 16; i++) v_desc[i] = 15 - i;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_flat  = '0;
        #1;
        check("reset.valid", int'(out_valid), 0);
        check("reset.max", int'(max_o), 0);
        check("reset.argmax", int'(argmax_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_single("desc",  v_desc,  15, 0);
        run_single("zero",  v_zero,  0, 15);
        run_single("mixed", v_mixed, 11, 2);
        run_single("full",  v_full,  14, 12);
        run_single("last",  v_last,  15, 15);

        // Back-to-back stream of four vectors
        svec[0] = v_strm;  exp_mx[0] = 12;  exp_idx[0] = 1;
        svec[1] = v_mixed; exp_mx[1] = 11;  exp_idx[1] = 2;
        svec[2] = v_full;  exp_mx[2] = 14;  exp_idx[2] = 12;
        svec[3] = v_neg;   exp_mx[3] = -16; exp_idx[3] = 15;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 9; s++) begin
            if (s >= 4 && s < 8)
                check_out($sformatf("stream%0d", s - 4), 1, exp_mx[s-4], exp_idx[s-4]);
            else
                check_out($sformatf("stream_idle%0d", s), 0, 0, 0);
            if (s < 4) begin
                in_flat  = pack(svec[s]);
                in_valid = 1'b1;
            end else begin
                in_flat  = '0;
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Asynchronous reset while results are streaming out
        for (int s = 0; s < 6; s++) begin
            in_flat  = pack(v_full);
            in_valid = 1'b1;
            @(negedge clk);
        end
        check("pre_rst.valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid", int'(out_valid), 0);
        check("async_rst.max", int'(max_o), 0);
        check("async_rst.argmax", int'(argmax_o), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_flat  = '0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            check($sformatf("flushed%0d", s), int'(out_valid), 0);
        end

        run_single("recover", v_strm, 12, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
